// File: rtl/icache_dnreq_arb.sv
// icache downstream request arbiter.
// Shares the single downstream txreq slot between MSHR demand misses and
// prefetcher requests. Demand misses normally win, but a prefetch that keeps
// losing for PF_STARVE cycles is forced through. The number of accepted fills
// that have not yet completed is capped at MAX_OUTST.
//
// state | meaning
// IDLE  | output slot empty, downstream_txreq_vld=0
// SEND  | slot holds a request, downstream_txreq_vld=1
module icache_dnreq_arb #(
  parameter int ADDR_W    = 40,
  parameter int ID_W      = 4,
  parameter int MAX_OUTST = 8,
  parameter int PF_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prefetch_enable,
  input  logic              miss_req_vld,
  output logic              miss_req_rdy,
  input  logic [ADDR_W-1:0] miss_req_addr,
  input  logic [ID_W-1:0]   miss_req_entry_id,
  input  logic              pf_req_vld,
  output logic              pf_req_rdy,
  input  logic [ADDR_W-1:0] pf_req_addr,
  input  logic [ID_W-1:0]   pf_req_entry_id,
  output logic              downstream_txreq_vld,
  input  logic              downstream_txreq_rdy,
  output logic [ADDR_W:0]   downstream_txreq_pld,
  output logic [ID_W-1:0]   downstream_txreq_entry_id,
  input  logic              fill_cmpl_vld,
  output logic [7:0]        outst_cnt,
  output logic              credit_err
);

  localparam int SW = $clog2(PF_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(PF_STARVE);
  localparam logic [7:0]    OUTST_MAX  = 8'(MAX_OUTST);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e            state_q;
  logic [ADDR_W:0]   pld_q;
  logic [ID_W-1:0]   id_q;
  logic [7:0]        outst_q, outst_d;
  logic              err_q, err_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic slot_free, can_acc, pf_ok, force_pf, miss_gnt, pf_gnt;
  logic miss_acc, pf_acc, acc, tx_hs;

  // Grant and accept decode: one winner per cycle, only when the slot and a credit are free.
  always_comb begin
    tx_hs     = (state_q == SEND) & downstream_txreq_rdy;
    slot_free = (state_q == IDLE) | tx_hs;
    // A same-cycle completion is deliberately not counted here; the credit frees next cycle.
    can_acc   = slot_free & (outst_q < OUTST_MAX);
    pf_ok     = pf_req_vld & prefetch_enable;
    force_pf  = pf_ok & (starve_q >= STARVE_MAX);
    miss_gnt  = ~force_pf & miss_req_vld;
    pf_gnt    = force_pf | (~miss_req_vld & pf_ok);
    miss_acc  = can_acc & miss_gnt;
    pf_acc    = can_acc & pf_gnt;
    acc       = miss_acc | pf_acc;
  end

  assign miss_req_rdy              = miss_acc;
  assign pf_req_rdy                = pf_acc;
  assign downstream_txreq_vld      = (state_q == SEND);
  assign downstream_txreq_pld      = pld_q;
  assign downstream_txreq_entry_id = id_q;
  assign outst_cnt                 = outst_q;
  assign credit_err                = err_q;

  // Next-state for the credit counter, sticky error flag and starvation counter.
  always_comb begin
    outst_d  = outst_q;
    err_d    = err_q;
    starve_d = starve_q;
    if (fill_cmpl_vld && (outst_q == 8'd0)) begin
      err_d = 1'b1;
    end
    if (acc && !fill_cmpl_vld) begin
      outst_d = outst_q + 8'd1;
    end else if (!acc && fill_cmpl_vld && (outst_q != 8'd0)) begin
      outst_d = outst_q - 8'd1;
    end
    if (!pf_ok || pf_acc) begin
      starve_d = '0;
    end else if (starve_q < STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Output slot FSM; slot contents only change on an accept, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pld_q   <= '0;
      id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc) state_q <= SEND;
        end
        SEND: begin
          if (tx_hs && !acc) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (miss_acc) begin
        pld_q <= {1'b0, miss_req_addr};
        id_q  <= miss_req_entry_id;
      end else if (pf_acc) begin
        pld_q <= {1'b1, pf_req_addr};
        id_q  <= pf_req_entry_id;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q  <= '0;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      outst_q  <= outst_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_icache_dnreq_arb.sv
// Scoreboard bench for icache_dnreq_arb: stimulus pushes the expected downstream
// request for each cycle it expects an accept; a negedge monitor pops on every
// downstream handshake.
module tb_icache_dnreq_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prefetch_enable = 1'b0;
  logic        miss_req_vld = 1'b0;
  logic        miss_req_rdy;
  logic [39:0] miss_req_addr = '0;
  logic [3:0]  miss_req_entry_id = '0;
  logic        pf_req_vld = 1'b0;
  logic        pf_req_rdy;
  logic [39:0] pf_req_addr = '0;
  logic [3:0]  pf_req_entry_id = '0;
  logic        downstream_txreq_vld;
  logic        downstream_txreq_rdy = 1'b1;
  logic [40:0] downstream_txreq_pld;
  logic [3:0]  downstream_txreq_entry_id;
  logic        fill_cmpl_vld = 1'b0;
  logic [7:0]  outst_cnt;
  logic        credit_err;

  int n_checks = 0;
  int n_fail = 0;
  logic [44:0] exp_q[$];

  icache_dnreq_arb #(.ADDR_W(40), .ID_W(4), .MAX_OUTST(8), .PF_STARVE(4)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .prefetch_enable           (prefetch_enable),
    .miss_req_vld              (miss_req_vld),
    .miss_req_rdy              (miss_req_rdy),
    .miss_req_addr             (miss_req_addr),
    .miss_req_entry_id         (miss_req_entry_id),
    .pf_req_vld                (pf_req_vld),
    .pf_req_rdy                (pf_req_rdy),
    .pf_req_addr               (pf_req_addr),
    .pf_req_entry_id           (pf_req_entry_id),
    .downstream_txreq_vld      (downstream_txreq_vld),
    .downstream_txreq_rdy      (downstream_txreq_rdy),
    .downstream_txreq_pld      (downstream_txreq_pld),
    .downstream_txreq_entry_id (downstream_txreq_entry_id),
    .fill_cmpl_vld             (fill_cmpl_vld),
    .outst_cnt                 (outst_cnt),
    .credit_err                (credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every downstream handshake must match the oldest expected request.
  always @(negedge clk) begin
    if (rst_n && downstream_txreq_vld && downstream_txreq_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL txreq_spurious: got pld 0x%0h id %0d, expected nothing",
                 downstream_txreq_pld, downstream_txreq_entry_id);
      end else begin
        logic [44:0] e;
        e = exp_q.pop_front();
        chk("txreq_pld", 64'(downstream_txreq_pld), 64'(e[44:4]));
        chk("txreq_id", 64'(downstream_txreq_entry_id), 64'(e[3:0]));
      end
    end
  end

  // One cycle of stimulus. Called just after a rising edge; returns just after the next one.
  task automatic cyc(input logic mv, input logic [39:0] ma, input logic [3:0] mi,
                     input logic pv, input logic [39:0] pa, input logic [3:0] pi,
                     input logic cmpl, input logic emr, input logic epr, input string nm);
    miss_req_vld      = mv;
    miss_req_addr     = ma;
    miss_req_entry_id = mi;
    pf_req_vld        = pv;
    pf_req_addr       = pa;
    pf_req_entry_id   = pi;
    fill_cmpl_vld     = cmpl;
    @(negedge clk);
    chk({nm, "_miss_rdy"}, 64'(miss_req_rdy), 64'(emr));
    chk({nm, "_pf_rdy"}, 64'(pf_req_rdy), 64'(epr));
    if (emr) exp_q.push_back({1'b0, ma, mi});
    else if (epr) exp_q.push_back({1'b1, pa, pi});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic cmpl);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0, cmpl, 1'b0, 1'b0, "idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 64'(downstream_txreq_vld), 64'd0);
    chk("rst_pld", 64'(downstream_txreq_pld), 64'd0);
    chk("rst_id", 64'(downstream_txreq_entry_id), 64'd0);
    chk("rst_outst", 64'(outst_cnt), 64'd0);
    chk("rst_err", 64'(credit_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: three back-to-back misses
    cyc(1'b1, 40'h100, 4'd1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "t1a");
    chk("t1_vld_latency", 64'(downstream_txreq_vld), 64'd1);
    cyc(1'b1, 40'h140, 4'd2, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "t1b");
    cyc(1'b1, 40'h180, 4'd3, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "t1c");
    idle(1, 1'b0);
    chk("t1_outst", 64'(outst_cnt), 64'd3);
    chk("t1_vld_off", 64'(downstream_txreq_vld), 64'd0);
    idle(3, 1'b1);
    chk("t1_drain", 64'(outst_cnt), 64'd0);

    // 2: miss and prefetch both valid, prefetch forced after 4 losses
    prefetch_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic em;
      em = (i != 4);
      cyc(1'b1, 40'h1000 + 40'(i * 64), 4'(i), 1'b1, 40'h8000, 4'd9, 1'b0, em, ~em, "t2");
    end
    idle(1, 1'b0);
    chk("t2_outst", 64'(outst_cnt), 64'd6);
    idle(6, 1'b1);

    // 3: credit limit
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 40'h2000 + 40'(i * 64), 4'(i), 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "t3_fill");
    chk("t3_full", 64'(outst_cnt), 64'd8);
    cyc(1'b1, 40'h3000, 4'hA, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, "t3_ninth");
    cyc(1'b1, 40'h3000, 4'hA, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "t3_cmpl_same");
    chk("t3_after_cmpl", 64'(outst_cnt), 64'd7);
    cyc(1'b1, 40'h3000, 4'hA, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "t3_unblock");
    idle(1, 1'b0);
    chk("t3_outst", 64'(outst_cnt), 64'd8);
    idle(8, 1'b1);

    // 4: downstream stall holds the slot, then back-to-back on release
    downstream_txreq_rdy = 1'b0;
    prefetch_enable = 1'b0;
    cyc(1'b1, 40'h4440, 4'd5, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "t4_a");
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 40'h5580, 4'd6, 1'b1, 40'h9000, 4'd7, 1'b0, 1'b0, 1'b0, "t4_stall");
      chk("t4_vld", 64'(downstream_txreq_vld), 64'd1);
      chk("t4_pld", 64'(downstream_txreq_pld), 64'h0_0000_4440);
      chk("t4_id", 64'(downstream_txreq_entry_id), 64'd5);
    end
    downstream_txreq_rdy = 1'b1;
    cyc(1'b1, 40'h5580, 4'd6, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "t4_b2b");
    chk("t4_b_pld", 64'(downstream_txreq_pld), 64'h0_0000_5580);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // 5: prefetch disabled; no starvation build-up, so a miss still wins afterwards
    for (int i = 0; i < 10; i++)
      cyc(1'b0, '0, '0, 1'b1, 40'hA000, 4'd8, 1'b0, 1'b0, 1'b0, "t5_blocked");
    prefetch_enable = 1'b1;
    cyc(1'b1, 40'h6000, 4'd2, 1'b1, 40'hA000, 4'd8, 1'b0, 1'b1, 1'b0, "t5_miss_wins");
    cyc(1'b0, '0, '0, 1'b1, 40'hA000, 4'd8, 1'b0, 1'b0, 1'b1, "t5_pf_alone");
    idle(1, 1'b0);
    chk("t5_outst", 64'(outst_cnt), 64'd2);
    idle(2, 1'b1);

    // 6: underflow, simultaneous accept/completion, async reset mid-send
    idle(1, 1'b1);
    chk("t6_err", 64'(credit_err), 64'd1);
    chk("t6_outst0", 64'(outst_cnt), 64'd0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 40'h7000 + 40'(i * 64), 4'(i), 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "t6_fill");
    cyc(1'b1, 40'h7100, 4'd4, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, "t6_same");
    idle(1, 1'b0);
    chk("t6_outst3", 64'(outst_cnt), 64'd3);
    chk("t6_err_sticky", 64'(credit_err), 64'd1);
    downstream_txreq_rdy = 1'b0;
    cyc(1'b1, 40'h7200, 4'd5, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "t6_load");
    chk("t6_send_vld", 64'(downstream_txreq_vld), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_vld", 64'(downstream_txreq_vld), 64'd0);
    chk("t6_async_outst", 64'(outst_cnt), 64'd0);
    chk("t6_async_err", 64'(credit_err), 64'd0);
    chk("t6_pending", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    miss_req_vld = 1'b0;
    downstream_txreq_rdy = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2, 1'b0);
    chk("end_vld", 64'(downstream_txreq_vld), 64'd0);
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
